// File: rtl/ixc_sample_capture_if.sv
// Probe/sample bus for ixc_sample_capture: live probe inputs, capture controls,
// held sample vector and the valid/ready FIFO read port.
interface ixc_sample_capture_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16
);
  localparam int DW = WIDTH * CHANNELS;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] v;
  logic [1:0]    mode;
  logic          sample_en;
  logic          clear;
  logic [DW-1:0] sv;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          overflow;
  logic          single_done;

  modport master (
    output v, mode, sample_en, clear, out_ready,
    input  sv, out_valid, out_data, count, overflow, single_done
  );

  modport slave (
    input  v, mode, sample_en, clear, out_ready,
    output sv, out_valid, out_data, count, overflow, single_done
  );
endinterface

// File: rtl/ixc_sample_capture.sv
// Multi-channel probe sampler: holds a registered sample vector and captures
// samples (continuous, on-change or single-shot) into a DEPTH-entry FIFO.
module ixc_sample_capture #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ixc_sample_capture_if.slave  bus
);
  localparam int DW = WIDTH * CHANNELS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_CONT   = 2'b01,
    MODE_CHANGE = 2'b10,
    MODE_SINGLE = 2'b11
  } mode_e;

  mode_e         mode_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          push_ok_s;

  logic [DW-1:0] sv_q, sv_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          single_done_q, single_done_d;
  logic [DW-1:0] mem_q [DEPTH];

  assign mode_s    = mode_e'(bus.mode);
  assign full_s    = (count_q == FULL_CNT);
  assign pop_s     = (count_q != {CW{1'b0}}) && bus.out_ready;
  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign push_ok_s = push_s && (!full_s || pop_s);

  // Push decision per capture mode, evaluated on this cycle's inputs.
  always_comb begin
    push_s = 1'b0;
    case (mode_s)
      MODE_OFF:    push_s = 1'b0;
      MODE_CONT:   push_s = bus.sample_en;
      MODE_CHANGE: push_s = (bus.v != sv_q);
      MODE_SINGLE: push_s = bus.sample_en && !single_done_q;
      default:     push_s = 1'b0;
    endcase
  end

  // Next-state for the sample vector, FIFO pointers/occupancy and status flags.
  always_comb begin
    sv_d          = sv_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    single_done_d = single_done_q;

    if (mode_s != MODE_OFF) begin
      sv_d = bus.v;
    end else begin
      sv_d = sv_q;
    end

    if (bus.clear) begin
      wr_ptr_d      = {AW{1'b0}};
      rd_ptr_d      = {AW{1'b0}};
      count_d       = {CW{1'b0}};
      overflow_d    = 1'b0;
      single_done_d = 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push_s && !push_ok_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      // Leaving SINGLE re-arms it; a dropped single-shot push still counts as taken.
      if (mode_s != MODE_SINGLE) begin
        single_done_d = 1'b0;
      end else if (push_s) begin
        single_done_d = 1'b1;
      end else begin
        single_done_d = single_done_q;
      end
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q          <= {DW{1'b0}};
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= {CW{1'b0}};
      overflow_q    <= 1'b0;
      single_done_q <= 1'b0;
    end else begin
      sv_q          <= sv_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      single_done_q <= single_done_d;
    end
  end

  // Sample storage; stale entries are never visible because out_data is masked.
  always_ff @(posedge clk) begin
    if (push_ok_s && !bus.clear) begin
      mem_q[wr_ptr_q] <= bus.v;
    end
  end

  assign bus.sv          = sv_q;
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.single_done = single_done_q;
  assign bus.out_valid   = (count_q != {CW{1'b0}});
  assign bus.out_data    = (count_q != {CW{1'b0}}) ? mem_q[rd_ptr_q] : {DW{1'b0}};
endmodule
